serial_rx_fifo_writer: RTL

Asynchronous serial receiver that sits directly upstream of the team's FIFO. It oversamples a single RXD line and deserialises one DATA_WIDTH-bit frame (start bit, LSB-first data, stop bit). It pushes each good word into the FIFO with a one-cycle write strobe while honouring the FIFO's Full flag. It also reports framing errors and overruns to the control logic.

---
 rtl/serial_rx_fifo_writer_pkg.sv | 23 ++
 rtl/serial_rx_fifo_writer_if.sv | 25 ++
 rtl/serial_rx_fifo_writer_rx_sync_edge.sv | 30 +++
 rtl/serial_rx_fifo_writer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/serial_rx_fifo_writer_pkg.sv
// Shared definitions for the serial receiver that feeds the FIFO write port:
// state encoding and the payload width agreed with the FIFO.
package serial_rx_fifo_writer_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 10;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_PUSH    = 3'd4;
  localparam logic [2:0] ST_WAIT_HI = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    START   = ST_START,
    DATA    = ST_DATA,
    STOP    = ST_STOP,
    PUSH    = ST_PUSH,
    WAIT_HI = ST_WAIT_HI
  } rx_state_e;

endpackage

// File: rtl/serial_rx_fifo_writer_if.sv
// FIFO write-side and status bundle between the receiver (master) and the
// FIFO / control logic (slave).
interface serial_rx_fifo_writer_if
  import serial_rx_fifo_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic                  fifo_full;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] fifo_din;
  logic                  fifo_wr_en;
  logic                  frame_err;
  logic                  overrun;
  logic                  busy;

  modport master (
    input  fifo_full, clr_err,
    output fifo_din, fifo_wr_en, frame_err, overrun, busy
  );

  modport slave (
    output fifo_full, clr_err,
    input  fifo_din, fifo_wr_en, frame_err, overrun, busy
  );
endinterface

// File: rtl/serial_rx_fifo_writer_rx_sync_edge.sv
// Two-flop synchroniser for the asynchronous RXD line plus a falling-edge
// detector on the synchronised level. All flops reset to the idle-high value.
module rx_sync_edge (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic level_o,
  output logic fall_c_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign level_o  = sync2_q;
  assign fall_c_o = prev_q & ~sync2_q;

endmodule

// File: rtl/serial_rx_fifo_writer.sv
// Oversampling serial receiver: deserialises start/LSB-first data/stop frames
// and writes each good word to the FIFO, flagging framing errors and overruns.
module serial_rx_fifo_writer
  import serial_rx_fifo_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    rxd_i,
  serial_rx_fifo_writer_if.master bus
);

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] HALF_LAST = CNT_WIDTH'(CLKS_PER_BIT / 2 - 2);
  localparam logic [CNT_WIDTH-1:0] BIT_LAST  = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  logic rx_level;
  logic rx_fall;

  rx_sync_edge u_sync (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .d_i      (rxd_i),
    .level_o  (rx_level),
    .fall_c_o (rx_fall)
  );

  rx_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  wr_q, wr_d;
  logic                  fe_q, fe_d;
  logic                  ovr_q, ovr_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      din_q   <= '0;
      wr_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  // Counters restart from zero on every transition so sample points never drift.
  // FIFO_FULL is taken at the stop-sample edge so the write strobe is a flop
  // that is high for exactly the PUSH cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_WIDTH'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    din_d   = din_q;
    wr_d    = 1'b0;
    fe_d    = 1'b0;
    ovr_d   = ovr_q & ~bus.clr_err;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (rx_fall) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_level ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_level, shift_q[DATA_WIDTH-1:1]};
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_level) begin
            state_d = PUSH;
            if (!bus.fifo_full) begin
              wr_d  = 1'b1;
              din_d = shift_q;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            fe_d    = 1'b1;
            state_d = WAIT_HI;
          end
        end
      end
      PUSH: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      WAIT_HI: begin
        cnt_d = '0;
        if (rx_level) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.fifo_din   = din_q;
  assign bus.fifo_wr_en = wr_q;
  assign bus.frame_err  = fe_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = busy_q;

endmodule
